// File: rtl/vc_fifo6_pkg.sv
// Shared constants and gray mod-6 helpers for the six-entry flit FIFO.
package vc_fifo6_pkg;
  localparam int DEPTH = 6;

  localparam logic [2:0] G0 = 3'b000;
  localparam logic [2:0] G1 = 3'b001;
  localparam logic [2:0] G2 = 3'b011;
  localparam logic [2:0] G3 = 3'b010;
  localparam logic [2:0] G4 = 3'b110;
  localparam logic [2:0] G5 = 3'b100;

  // Unused codes decode to slot 0 so a stray pointer never indexes past the array.
  function automatic logic [2:0] gray2idx(input logic [2:0] g);
    case (g)
      G0:      gray2idx = 3'd0;
      G1:      gray2idx = 3'd1;
      G2:      gray2idx = 3'd2;
      G3:      gray2idx = 3'd3;
      G4:      gray2idx = 3'd4;
      G5:      gray2idx = 3'd5;
      default: gray2idx = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] next_gray(input logic [2:0] g);
    case (g)
      G0:      next_gray = G1;
      G1:      next_gray = G2;
      G2:      next_gray = G3;
      G3:      next_gray = G4;
      G4:      next_gray = G5;
      default: next_gray = G0;
    endcase
  endfunction
endpackage

// File: rtl/vc_fifo6_gray6_ptr.sv
// Gray mod-6 pointer with a lap (wrap) bit that flips on each 100->000 step.
module gray6_ptr
  import vc_fifo6_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [2:0] gray,
  output logic       wrap
);
  logic [2:0] gray_q, gray_d;
  logic       wrap_q, wrap_d;

  always_comb begin
    gray_d = gray_q;
    wrap_d = wrap_q;
    if (en) begin
      gray_d = next_gray(gray_q);
      if (gray_q == G5) wrap_d = ~wrap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gray_q <= G0;
      wrap_q <= 1'b0;
    end else begin
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign gray = gray_q;
  assign wrap = wrap_q;
endmodule

// File: rtl/vc_fifo6.sv
// Six-entry first-word-fall-through flit FIFO with gray mod-6 pointers.
module vc_fifo6
  import vc_fifo6_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [2:0]       count,
  output logic [2:0]       wr_ptr_gray,
  output logic [2:0]       rd_ptr_gray,
  output logic             ovf_err,
  output logic             udf_err
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_wrap, rd_wrap;
  logic             wr_acc, rd_acc;
  logic [2:0]       count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;

  gray6_ptr u_wr_ptr (.clk(clk), .reset(reset), .en(wr_acc), .gray(wr_ptr_gray), .wrap(wr_wrap));
  gray6_ptr u_rd_ptr (.clk(clk), .reset(reset), .en(rd_acc), .gray(rd_ptr_gray), .wrap(rd_wrap));

  assign empty  = (wr_ptr_gray == rd_ptr_gray) && (wr_wrap == rd_wrap);
  assign full   = (wr_ptr_gray == rd_ptr_gray) && (wr_wrap != rd_wrap);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + 3'd1;
    else if (rd_acc && !wr_acc) count_d = count_q - 3'd1;
    ovf_d = wr_en && full;
    udf_d = rd_en && empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 3'd0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is not reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem_q[gray2idx(wr_ptr_gray)] <= wr_data;
  end

  assign rd_data = mem_q[gray2idx(rd_ptr_gray)];
  assign count   = count_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
endmodule
